instr_cycle_ctl: RTL and testbench
==================================

# instr_cycle_ctl

Instruction-cycle controller for the 8-bit RISC CPU. Consumes the `fetch` phase strobe from the CPU clock generator and runs an 8-state sequencer, one state per `clk`, locked to that strobe. Each state decodes the 3-bit opcode from the instruction register and drives PC, IR, accumulator, memory and data-bus control strobes. It also holds the CPU halted after HLT and flags any loss of phase lock with the clock generator.

## Interface
- No parameters. Opcode map is fixed: HLT=000, SKZ=001, ADD=010, ANDD=011, XORR=100, LDA=101, STO=110, JMP=111. ALU ops = ADD, ANDD, XORR, LDA.
- clk  in  1  system clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- fetch  in  1  phase strobe from clock generator: high 4 cycles, low 4 cycles, repeating
- opcode  in  3  IR[15:13], valid from state S2 onward
- zero  in  1  accumulator-zero flag
- inc_pc  out  1  increment program counter
- load_ir  out  1  load instruction-register byte
- rd  out  1  memory read
- wr  out  1  memory write
- load_acc  out  1  load accumulator from ALU
- load_pc  out  1  load PC from IR address field
- datactl_ena  out  1  drive ALU result onto data bus
- halt  out  1  CPU halted
- sync_err  out  1  sticky phase-lock error

## Operation
- States: IDLE, S0..S7, HALT. Internal `ena` bit.
- Reset: state=IDLE, `ena`=0, all outputs 0 (including `halt` and `sync_err`).
- IDLE: stay until `fetch` is sampled 1. On that edge, set `ena`=1 and go to S0.
- S0..S7 advance one per clock. S7 goes to S0.
- Outputs are registered. They are written on the edge that enters a state, are valid for that state's cycle, and use `opcode`/`zero` as sampled on that edge. Any strobe not listed for a state is 0.
  - S0: rd, load_ir, inc_pc (instruction high byte)
  - S1: rd, load_ir, inc_pc (low byte)
  - S2: none
  - S3: if HLT, halt=1 and the next state is HALT instead of S4. Otherwise none.
  - S4: ALU op → rd. JMP → load_pc. STO → datactl_ena. SKZ → inc_pc=zero. HLT unreachable.
  - S5: ALU op → rd, load_acc. JMP → load_pc. STO → wr, datactl_ena. SKZ → none.
  - S6: STO → datactl_ena. SKZ → inc_pc=zero. Others none.
  - S7: none
- HALT: `halt`=1 is held and every other strobe is 0. HALT is left only by `rst`. `fetch` is ignored in HALT.
- Phase check, active only while `ena`=1 and not in HALT: `fetch` must be 1 in S7, S0, S1, S2 and 0 in S3..S6.
  - A mismatch sampled in any state sets `sync_err`=1 on the next edge.
  - `sync_err` is sticky until `rst`.
  - The sequencer keeps running and does not resynchronise.
- The phase check is not applied in IDLE.

## Timing
- Lock latency: first cycle with `fetch`=1 in IDLE → S0 strobes (rd/load_ir/inc_pc) are visible on the next cycle.
- One instruction = 8 clocks. PC advances by 2 per instruction, plus 2 more for SKZ with `zero`=1 (S4 and S6).
- JMP holds load_pc for 2 cycles (S4, S5). The PC block takes the last value.
- STO: datactl_ena spans S4..S6. wr is a single cycle at S5, centred in the data-valid window.
- HLT: halt rises at S3 and stays high. No strobe pulses after it.
- `rst` mid-instruction: on that edge all outputs go to 0, state=IDLE, `ena`=0. Any in-flight wr is truncated to its current cycle.
- `rst` has priority over every transition, including HALT and the `sync_err` set.
- `fetch` glitches while `ena`=1 do not change state; they only raise `sync_err`.

## Test plan
- Lock: reset 3 cycles with `fetch` held 0, then apply the standard 4-high/4-low `fetch` pattern → first rd&load_ir&inc_pc the cycle after first `fetch`=1; exactly 2 inc_pc per 8 cycles; `sync_err`=0.
- ADD (opcode=010): → rd in S4 and S5, load_acc only in S5, wr/load_pc/datactl_ena never asserted.
- STO (110) then JMP (111): → STO gives datactl_ena in S4..S6 and wr only in S5. JMP gives load_pc in S4..S5 and no rd in S4/S5.
- SKZ (001): zero=1 → 4 inc_pc pulses (S0, S1, S4, S6). zero=0 → 2 pulses.
- HLT (000): → halt=1 from S3 and held for 50 further cycles with all strobes 0 while `fetch` keeps toggling. `rst` → halt=0, state IDLE, relock on next `fetch`.
- Phase fault: after lock, hold `fetch`=1 for 5 cycles instead of 4 → `sync_err`=1 one cycle after the sample in S3, and it stays high. Sequencer strobes continue on the 8-cycle cadence. `rst` clears `sync_err`.

Source files
------------

// File: rtl/instr_cycle_ctl.sv
// ---------------------------------------------------------------------------
// instr_cycle_ctl
//
// Instruction-cycle controller for the 8-bit RISC CPU. An 8-state sequencer
// (S0..S7, one state per clk) locks onto the `fetch` phase strobe coming from
// the clock generator. In each state it decodes the opcode and drives the
// PC, IR, accumulator, memory and data-bus strobes. After HLT it parks in
// HALT until reset. While locked it keeps checking `fetch` against the
// expected phase and raises a sticky error on any disagreement.
//
// Handshake / timing: there is no valid/ready handshake. Every strobe is
// registered. It is written on the edge that enters a state and is valid for
// that whole state cycle. It is computed from the opcode/zero values sampled
// on that same edge.
//
// Ports:
//   clk          in   system clock, all logic on posedge
//   rst          in   synchronous, active-high reset
//   fetch        in   phase strobe (4 high / 4 low)
//   opcode[2:0]  in   IR[15:13], valid from S2 onward
//   zero         in   accumulator-zero flag
//   inc_pc       out  increment program counter
//   load_ir      out  load instruction-register byte
//   rd           out  memory read
//   wr           out  memory write
//   load_acc     out  load accumulator from ALU
//   load_pc      out  load PC from IR address field
//   datactl_ena  out  drive ALU result onto data bus
//   halt         out  CPU halted
//   sync_err     out  sticky phase-lock error
//   dbg_state_o  out  current sequencer state (debug)
// ---------------------------------------------------------------------------
module instr_cycle_ctl (
   input  logic       clk,
   input  logic       rst,
   input  logic       fetch,
   input  logic [2:0] opcode,
   input  logic       zero,
   output logic       inc_pc,
   output logic       load_ir,
   output logic       rd,
   output logic       wr,
   output logic       load_acc,
   output logic       load_pc,
   output logic       datactl_ena,
   output logic       halt,
   output logic       sync_err,
   output logic [3:0] dbg_state_o
);

   typedef enum logic [3:0] {
      ST_IDLE = 4'd0,
      ST_S0   = 4'd1,
      ST_S1   = 4'd2,
      ST_S2   = 4'd3,
      ST_S3   = 4'd4,
      ST_S4   = 4'd5,
      ST_S5   = 4'd6,
      ST_S6   = 4'd7,
      ST_S7   = 4'd8,
      ST_HALT = 4'd9
   } state_t;

   localparam logic [2:0] OP_HLT  = 3'b000;
   localparam logic [2:0] OP_SKZ  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_ANDD = 3'b011;
   localparam logic [2:0] OP_XORR = 3'b100;
   localparam logic [2:0] OP_LDA  = 3'b101;
   localparam logic [2:0] OP_STO  = 3'b110;
   localparam logic [2:0] OP_JMP  = 3'b111;

   state_t state_q, state_d;
   logic   ena_q, ena_d;
   logic   sync_err_q, sync_err_d;
   logic   inc_pc_q, inc_pc_d;
   logic   load_ir_q, load_ir_d;
   logic   rd_q, rd_d;
   logic   wr_q, wr_d;
   logic   load_acc_q, load_acc_d;
   logic   load_pc_q, load_pc_d;
   logic   datactl_q, datactl_d;
   logic   halt_q, halt_d;

   logic   alu_op;
   logic   is_sto;
   logic   is_jmp;
   logic   is_skz;
   logic   fetch_exp;

   assign alu_op = (opcode == OP_ADD) || (opcode == OP_ANDD) ||
                   (opcode == OP_XORR) || (opcode == OP_LDA);
   assign is_sto = (opcode == OP_STO);
   assign is_jmp = (opcode == OP_JMP);
   assign is_skz = (opcode == OP_SKZ);

   // fetch is high in S7 and S0..S2 and low in S3..S6 when phase-locked.
   assign fetch_exp = (state_q == ST_S7) || (state_q == ST_S0) ||
                      (state_q == ST_S1) || (state_q == ST_S2);

   always_comb begin
      state_d    = state_q;
      ena_d      = ena_q;
      sync_err_d = sync_err_q;
      inc_pc_d   = 1'b0;
      load_ir_d  = 1'b0;
      rd_d       = 1'b0;
      wr_d       = 1'b0;
      load_acc_d = 1'b0;
      load_pc_d  = 1'b0;
      datactl_d  = 1'b0;
      halt_d     = 1'b0;

      // The sequencer never resynchronises. A phase mismatch only flags it.
      if (ena_q && (state_q != ST_HALT) && (fetch != fetch_exp)) begin
         sync_err_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (fetch) begin
               state_d = ST_S0;
               ena_d   = 1'b1;
            end
         end
         ST_S0:   state_d = ST_S1;
         ST_S1:   state_d = ST_S2;
         ST_S2:   state_d = ST_S3;
         ST_S3:   state_d = (opcode == OP_HLT) ? ST_HALT : ST_S4;
         ST_S4:   state_d = ST_S5;
         ST_S5:   state_d = ST_S6;
         ST_S6:   state_d = ST_S7;
         ST_S7:   state_d = ST_S0;
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_IDLE;
      endcase

      // Strobes are decoded for the state being entered, so they are
      // registered and aligned with that state's cycle.
      case (state_d)
         ST_S0, ST_S1: begin
            rd_d      = 1'b1;
            load_ir_d = 1'b1;
            inc_pc_d  = 1'b1;
         end
         ST_S3: begin
            halt_d = (opcode == OP_HLT);
         end
         ST_S4: begin
            rd_d      = alu_op;
            load_pc_d = is_jmp;
            datactl_d = is_sto;
            inc_pc_d  = is_skz && zero;
         end
         ST_S5: begin
            rd_d       = alu_op;
            load_acc_d = alu_op;
            load_pc_d  = is_jmp;
            wr_d       = is_sto;
            datactl_d  = is_sto;
         end
         ST_S6: begin
            datactl_d = is_sto;
            inc_pc_d  = is_skz && zero;
         end
         ST_HALT: begin
            halt_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         ena_q      <= 1'b0;
         sync_err_q <= 1'b0;
         inc_pc_q   <= 1'b0;
         load_ir_q  <= 1'b0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
         load_acc_q <= 1'b0;
         load_pc_q  <= 1'b0;
         datactl_q  <= 1'b0;
         halt_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ena_q      <= ena_d;
         sync_err_q <= sync_err_d;
         inc_pc_q   <= inc_pc_d;
         load_ir_q  <= load_ir_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         load_acc_q <= load_acc_d;
         load_pc_q  <= load_pc_d;
         datactl_q  <= datactl_d;
         halt_q     <= halt_d;
      end
   end

   assign inc_pc      = inc_pc_q;
   assign load_ir     = load_ir_q;
   assign rd          = rd_q;
   assign wr          = wr_q;
   assign load_acc    = load_acc_q;
   assign load_pc     = load_pc_q;
   assign datactl_ena = datactl_q;
   assign halt        = halt_q;
   assign sync_err    = sync_err_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_instr_cycle_ctl.sv
// ---------------------------------------------------------------------------
// tb_instr_cycle_ctl
//
// Directed bench for instr_cycle_ctl. The outputs are observed as a 9-bit
// vector {inc_pc, load_ir, rd, wr, load_acc, load_pc, datactl_ena, halt,
// sync_err}. It is compared once per cycle, 1 time unit after the rising
// edge, against hand-written per-state values for each opcode.
// ---------------------------------------------------------------------------
module tb_instr_cycle_ctl;

   logic       clk;
   logic       rst;
   logic       fetch;
   logic [2:0] opcode;
   logic       zero;
   logic       inc_pc, load_ir, rd, wr, load_acc, load_pc, datactl_ena;
   logic       halt, sync_err;
   logic [3:0] dbg_state;

   logic [8:0] obs_vec;
   logic [8:0] exp_q[$];
   logic       exp_sync;
   int         n_checks;
   int         n_fails;

   localparam logic [2:0] HLT  = 3'b000;
   localparam logic [2:0] SKZ  = 3'b001;
   localparam logic [2:0] ADD  = 3'b010;
   localparam logic [2:0] ANDD = 3'b011;
   localparam logic [2:0] XORR = 3'b100;
   localparam logic [2:0] LDA  = 3'b101;
   localparam logic [2:0] STO  = 3'b110;
   localparam logic [2:0] JMP  = 3'b111;

   assign obs_vec = {inc_pc, load_ir, rd, wr, load_acc, load_pc, datactl_ena, halt, sync_err};

   instr_cycle_ctl dut (
      .clk         (clk),
      .rst         (rst),
      .fetch       (fetch),
      .opcode      (opcode),
      .zero        (zero),
      .inc_pc      (inc_pc),
      .load_ir     (load_ir),
      .rd          (rd),
      .wr          (wr),
      .load_acc    (load_acc),
      .load_pc     (load_pc),
      .datactl_ena (datactl_ena),
      .halt        (halt),
      .sync_err    (sync_err),
      .dbg_state_o (dbg_state)
   );

   // clock / reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [8:0] got, input logic [8:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Hand-derived strobe vectors for the cycle of state S<k>, sync_err excluded.
   function automatic logic [8:0] exp_vec(input logic [2:0] op, input logic z, input int k);
      logic alu;
      alu = (op == ADD) || (op == ANDD) || (op == XORR) || (op == LDA);
      case (k)
         0, 1: return 9'h1C0;
         3:    return (op == HLT) ? 9'h002 : 9'h000;
         4: begin
            if (alu)        return 9'h040;
            if (op == STO)  return 9'h004;
            if (op == JMP)  return 9'h008;
            if (op == SKZ)  return z ? 9'h100 : 9'h000;
            return 9'h000;
         end
         5: begin
            if (alu)        return 9'h050;
            if (op == STO)  return 9'h024;
            if (op == JMP)  return 9'h008;
            return 9'h000;
         end
         6: begin
            if (op == STO)  return 9'h004;
            if (op == SKZ)  return z ? 9'h100 : 9'h000;
            return 9'h000;
         end
         default: return 9'h000;
      endcase
   endfunction

   // driver tasks
   task automatic tick(input logic f);
      fetch = f;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input string tag, input int n);
      rst = 1'b1;
      for (int i = 0; i < n; i++) begin
         tick(1'b0);
         check_eq($sformatf("%s_rst%0d", tag, i), obs_vec, 9'h000);
      end
      rst = 1'b0;
      exp_sync = 1'b0;
   endtask

   // Runs n states S0..S(n-1) of one instruction. fault_k >= 0 drives fetch
   // high on the edge entering S<fault_k> (i.e. sampled in the previous state).
   task automatic run_instr(input string tag, input logic [2:0] op, input logic z,
                            input int n, input int fault_k, input int exp_inc);
      int inc_cnt;
      logic [8:0] exp;
      inc_cnt = 0;
      opcode = op;
      zero = z;
      for (int k = 0; k < n; k++) begin
         if (k == fault_k) exp_sync = 1'b1;
         exp_q.push_back(exp_vec(op, z, k) | {8'h00, exp_sync});
         tick((k < 4) || (k == fault_k));
         exp = exp_q.pop_front();
         check_eq($sformatf("%s_s%0d", tag, k), obs_vec, exp);
         inc_cnt += int'(inc_pc);
      end
      if (exp_inc >= 0) check_eq({tag, "_inc_cnt"}, 9'(inc_cnt), 9'(exp_inc));
   endtask

   initial begin
      n_checks = 0;
      n_fails = 0;
      exp_sync = 1'b0;
      rst = 1'b1;
      fetch = 1'b0;
      opcode = ADD;
      zero = 1'b0;

      do_reset("init", 3);
      // IDLE with fetch low stays quiet
      tick(1'b0);
      check_eq("idle0", obs_vec, 9'h000);
      tick(1'b0);
      check_eq("idle1", obs_vec, 9'h000);

      // lock and run the instruction mix back to back
      run_instr("add",   ADD,  1'b0, 8, -1, 2);
      run_instr("sto",   STO,  1'b0, 8, -1, 2);
      run_instr("jmp",   JMP,  1'b0, 8, -1, 2);
      run_instr("skz1",  SKZ,  1'b1, 8, -1, 4);
      run_instr("skz0",  SKZ,  1'b0, 8, -1, 2);
      run_instr("andd",  ANDD, 1'b1, 8, -1, 2);
      run_instr("xorr",  XORR, 1'b0, 8, -1, 2);
      run_instr("lda",   LDA,  1'b0, 8, -1, 2);

      // phase fault: fetch stays high through S3; strobes keep their cadence
      run_instr("fault", ADD,  1'b0, 8, 4, 2);
      run_instr("sticky", JMP, 1'b0, 8, -1, 2);
      do_reset("clr", 1);

      // relock, then reset in the middle of STO while wr is high
      tick(1'b0);
      check_eq("idle2", obs_vec, 9'h000);
      run_instr("sto_cut", STO, 1'b0, 6, -1, -1);
      do_reset("mid", 1);

      // HLT: halt from S3, held with everything else quiet while fetch toggles
      run_instr("hlt", HLT, 1'b0, 4, -1, -1);
      for (int j = 0; j < 50; j++) begin
         tick(((j / 4) % 2) == 1);
         check_eq($sformatf("halt_hold%0d", j), obs_vec, 9'h002);
      end
      do_reset("unhalt", 1);
      run_instr("relock", ADD, 1'b0, 8, -1, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
